// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: shows one digit at a time from a per-frame
// snapshot of the display word, with optional blanking gaps and a frame strobe.
module seg7_scan_ctrl #(
   parameter int DIGITS          = 8,
   parameter int CLK_DIV         = 50000,
   parameter int BLANK_CYC       = 0,
   parameter int SCAN_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW  = 0
) (
   input  logic                clkin,
   input  logic                reset,
   input  logic [4*DIGITS-1:0] datain,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   digit_en,
   input  logic                lz_blank,
   output logic [DIGITS-1:0]   scan,
   output logic [7:0]          seg7,
   output logic                frame_done
);
   localparam int CNT_MAX    = (CLK_DIV > BLANK_CYC) ? ((CLK_DIV > 2) ? CLK_DIV : 2)
                                                     : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
   localparam int CW         = $clog2(CNT_MAX);
   localparam int IW         = $clog2((DIGITS > 2) ? DIGITS : 2);
   localparam int SHOW_LAST  = CLK_DIV - 1;
   localparam int BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
   localparam logic SCAN_INV = (SCAN_ACTIVE_LOW != 0);
   localparam logic SEG_INV  = (SEG_ACTIVE_LOW != 0);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;
   localparam state_t START_ST = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                frame_end_s;
   logic                start_s;
   logic [4*DIGITS-1:0] dat_q, dat_s, tail_s;
   logic [DIGITS-1:0]   dp_q, dp_s, en_q, en_s;
   logic                lz_q, lz_s;
   logic                dp_bit_s, en_bit_s, lz_hide_s;
   logic [3:0]          nib_s;
   logic [DIGITS-1:0]   scan_act_s, scan_d, scan_q;
   logic [7:0]          seg_act_s, seg_d, seg_q;
   logic                fd_q;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0: hex_to_seg = 7'h3F;
         4'h1: hex_to_seg = 7'h06;
         4'h2: hex_to_seg = 7'h5B;
         4'h3: hex_to_seg = 7'h4F;
         4'h4: hex_to_seg = 7'h66;
         4'h5: hex_to_seg = 7'h6D;
         4'h6: hex_to_seg = 7'h7D;
         4'h7: hex_to_seg = 7'h07;
         4'h8: hex_to_seg = 7'h7F;
         4'h9: hex_to_seg = 7'h6F;
         4'hA: hex_to_seg = 7'h77;
         4'hB: hex_to_seg = 7'h7C;
         4'hC: hex_to_seg = 7'h39;
         4'hD: hex_to_seg = 7'h5E;
         4'hE: hex_to_seg = 7'h79;
         4'hF: hex_to_seg = 7'h71;
         default: hex_to_seg = 7'h00;
      endcase
   endfunction

   // Slot sequencer: BLANK/SHOW timing, digit index and end-of-frame detect.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CW'(1);
      idx_d       = idx_q;
      frame_end_s = 1'b0;
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CW'(BLANK_LAST)) begin
               state_d = ST_SHOW;
               cnt_d   = '0;
            end else begin
               state_d = ST_BLANK;
            end
         end
         ST_SHOW: begin
            if (cnt_q == CW'(SHOW_LAST)) begin
               cnt_d   = '0;
               state_d = START_ST;
               if (idx_q == IW'(DIGITS - 1)) begin
                  idx_d       = '0;
                  frame_end_s = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               state_d = ST_SHOW;
            end
         end
         default: begin
            state_d = START_ST;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
   end

   // The snapshot is taken as digit 0 begins and is used from that very cycle.
   always_comb begin
      start_s = (state_q == START_ST) && (idx_q == '0) && (cnt_q == '0);
      if (start_s) begin
         dat_s = datain;
         dp_s  = dp_in;
         en_s  = digit_en;
         lz_s  = lz_blank;
      end else begin
         dat_s = dat_q;
         dp_s  = dp_q;
         en_s  = en_q;
         lz_s  = lz_q;
      end
   end

   // Output decode; tail_s holds nibbles idx..DIGITS-1 for zero suppression.
   always_comb begin
      tail_s     = dat_s >> {idx_q, 2'b00};
      nib_s      = tail_s[3:0];
      dp_bit_s   = 1'(dp_s >> idx_q);
      en_bit_s   = 1'(en_s >> idx_q);
      lz_hide_s  = lz_s && (idx_q != '0) && (tail_s == '0);
      scan_act_s = '0;
      seg_act_s  = 8'h00;
      if ((state_q == ST_SHOW) && en_bit_s) begin
         scan_act_s = DIGITS'(1'b1) << idx_q;
         seg_act_s  = {dp_bit_s, lz_hide_s ? 7'h00 : hex_to_seg(nib_s)};
      end else begin
         scan_act_s = '0;
         seg_act_s  = 8'h00;
      end
      scan_d = scan_act_s ^ {DIGITS{SCAN_INV}};
      seg_d  = seg_act_s ^ {8{SEG_INV}};
   end

   // Sequencer state registers.
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         state_q <= START_ST;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Frame snapshot registers.
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         dat_q <= '0;
         dp_q  <= '0;
         en_q  <= '0;
         lz_q  <= 1'b0;
      end else begin
         dat_q <= dat_s;
         dp_q  <= dp_s;
         en_q  <= en_s;
         lz_q  <= lz_s;
      end
   end

   // Registered pin drivers; reset leaves everything dark.
   always_ff @(posedge clkin or negedge reset) begin
      if (!reset) begin
         scan_q <= {DIGITS{SCAN_INV}};
         seg_q  <= {8{SEG_INV}};
         fd_q   <= 1'b0;
      end else begin
         scan_q <= scan_d;
         seg_q  <= seg_d;
         fd_q   <= frame_end_s;
      end
   end

   assign scan       = scan_q;
   assign seg7       = seg_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: three parameter sets checked every cycle against
// a slot-arithmetic model, plus hand-computed literal checkpoints.
module tb_seg7_scan_ctrl;
   logic        clkin = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] datain = 32'h0;
   logic [7:0]  dp_in = 8'h0;
   logic [7:0]  digit_en = 8'hFF;
   logic        lz_blank = 1'b0;

   logic [3:0] scan0; logic [7:0] seg0; logic fd0;
   logic [0:0] scan1; logic [7:0] seg1; logic fd1;
   logic [2:0] scan2; logic [7:0] seg2; logic fd2;

   int vectors = 0;
   int miscompares = 0;

   localparam int ND    [3] = '{4, 1, 3};
   localparam int NC    [3] = '{4, 3, 1};
   localparam int NB    [3] = '{1, 0, 0};
   localparam int NSAL  [3] = '{1, 0, 1};
   localparam int NSEGL [3] = '{0, 1, 1};

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int          t       [3];
   bit          running [3];
   logic [31:0] s_dat   [3];
   logic [7:0]  s_dp    [3];
   logic [7:0]  s_en    [3];
   logic        s_lz    [3];

   always #5 clkin = ~clkin;

   seg7_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYC(1), .SCAN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)) u0 (
      .clkin(clkin), .reset(reset), .datain(datain[15:0]), .dp_in(dp_in[3:0]),
      .digit_en(digit_en[3:0]), .lz_blank(lz_blank), .scan(scan0), .seg7(seg0), .frame_done(fd0));
   seg7_scan_ctrl #(.DIGITS(1), .CLK_DIV(3), .BLANK_CYC(0), .SCAN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)) u1 (
      .clkin(clkin), .reset(reset), .datain(datain[3:0]), .dp_in(dp_in[0:0]),
      .digit_en(digit_en[0:0]), .lz_blank(lz_blank), .scan(scan1), .seg7(seg1), .frame_done(fd1));
   seg7_scan_ctrl #(.DIGITS(3), .CLK_DIV(1), .BLANK_CYC(0), .SCAN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u2 (
      .clkin(clkin), .reset(reset), .datain(datain[11:0]), .dp_in(dp_in[2:0]),
      .digit_en(digit_en[2:0]), .lz_blank(lz_blank), .scan(scan2), .seg7(seg2), .frame_done(fd2));

   function automatic logic [16:0] pk(input logic fd, input logic [7:0] sc, input logic [7:0] sg);
      return {fd, sc, sg};
   endfunction

   function automatic logic [16:0] actual(input int k);
      case (k)
         0: return {fd0, 4'b0000, scan0, seg0};
         1: return {fd1, 7'b0000000, scan1, seg1};
         default: return {fd2, 5'b00000, scan2, seg2};
      endcase
   endfunction

   // Position in frame decides everything: per digit NB dark cycles then NC lit cycles.
   function automatic logic [16:0] expect_out(input int k, input bit lit, input int tt);
      int slot, per, pos, dig;
      logic [7:0]  sc, sg, dmask;
      logic [31:0] upper;
      logic        fd;
      slot  = NC[k] + NB[k];
      per   = ND[k] * slot;
      pos   = tt % per;
      dig   = pos / slot;
      dmask = 8'((16'd1 << ND[k]) - 16'd1);
      sc = 8'h00; sg = 8'h00; fd = 1'b0;
      if (lit) begin
         fd = (pos == per - 1);
         if ((pos % slot) >= NB[k] && s_en[k][dig]) begin
            upper   = 32'((64'(s_dat[k]) & ((64'd1 << (4 * ND[k])) - 64'd1)) >> (4 * dig));
            sc[dig] = 1'b1;
            sg      = {s_dp[k][dig], seg_tab[upper[3:0]]};
            if (s_lz[k] && dig > 0 && upper == 32'd0) sg[6:0] = 7'h00;
         end
      end
      if (NSAL[k] != 0) sc = ~sc & dmask;
      if (NSEGL[k] != 0) sg = ~sg;
      return {fd, sc, sg};
   endfunction

   always @(posedge clkin) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset) begin
            running[k] = 1'b0;
         end else begin
            if (!running[k]) begin
               running[k] = 1'b1;
               t[k] = 0;
            end else begin
               t[k] = t[k] + 1;
            end
            if (t[k] % (ND[k] * (NC[k] + NB[k])) == 0) begin
               s_dat[k] = datain;
               s_dp[k]  = dp_in;
               s_en[k]  = digit_en;
               s_lz[k]  = lz_blank;
            end
         end
      end
   end

   always @(negedge clkin) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         logic [16:0] exp_v, act_v;
         exp_v = expect_out(k, reset && running[k], t[k]);
         act_v = actual(k);
         vectors++;
         if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model inst%0d t=%0d: fd/scan/seg got %b/%h/%h required %b/%h/%h",
                     k, t[k], act_v[16], act_v[15:8], act_v[7:0], exp_v[16], exp_v[15:8], exp_v[7:0]);
         end
      end
   end

   task automatic check_lit(input string name, input logic [16:0] act_v, input logic [16:0] req_v);
      vectors++;
      if (act_v !== req_v) begin
         miscompares++;
         $display("FAIL %s: fd/scan/seg got %b/%h/%h required %b/%h/%h", name,
                  act_v[16], act_v[15:8], act_v[7:0], req_v[16], req_v[15:8], req_v[7:0]);
      end
   endtask

   task automatic wait_t0(input int target);
      int n;
      n = 0;
      @(negedge clkin);
      while (!(running[0] && t[0] == target) && n < 500) begin
         @(negedge clkin);
         n++;
      end
      if (n >= 500) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_t0: t=%0d never reached, got %0d", target, t[0]);
      end
      #2;
   endtask

   initial begin
      #1 reset = 1'b0;
      datain = 32'h0000_12A8; dp_in = 8'h00; digit_en = 8'hFF; lz_blank = 1'b0;
      #2;
      check_lit("reset0", actual(0), pk(1'b0, 8'h0F, 8'h00));
      check_lit("reset1", actual(1), pk(1'b0, 8'h00, 8'hFF));
      repeat (3) @(negedge clkin);
      #2 reset = 1'b1;

      wait_t0(0);  check_lit("f0_blank0", actual(0), pk(1'b0, 8'h0F, 8'h00));
      wait_t0(1);  check_lit("f0_d0", actual(0), pk(1'b0, 8'h0E, 8'h7F));
                   check_lit("i1_d0", actual(1), pk(1'b0, 8'h01, 8'h80));
                   check_lit("i2_d1", actual(2), pk(1'b0, 8'h05, 8'h88));
      wait_t0(5);  check_lit("f0_blank1", actual(0), pk(1'b0, 8'h0F, 8'h00));
                   check_lit("i1_fd", actual(1), pk(1'b1, 8'h01, 8'h80));
                   check_lit("i2_d2_fd", actual(2), pk(1'b1, 8'h03, 8'hA4));
      wait_t0(6);  check_lit("f0_d1", actual(0), pk(1'b0, 8'h0D, 8'h77));
      wait_t0(7);
      datain = 32'h0000_0030; dp_in = 8'h08; lz_blank = 1'b1;
      wait_t0(11); check_lit("f0_d2_untorn", actual(0), pk(1'b0, 8'h0B, 8'h5B));
      wait_t0(18); check_lit("f0_d3_nofd", actual(0), pk(1'b0, 8'h07, 8'h06));
      wait_t0(19); check_lit("f0_d3_fd", actual(0), pk(1'b1, 8'h07, 8'h06));
      wait_t0(21); check_lit("lz_d0", actual(0), pk(1'b0, 8'h0E, 8'h3F));
      wait_t0(26); check_lit("lz_d1", actual(0), pk(1'b0, 8'h0D, 8'h4F));
      wait_t0(31); check_lit("lz_d2", actual(0), pk(1'b0, 8'h0B, 8'h00));
      wait_t0(36); check_lit("lz_d3_dp", actual(0), pk(1'b0, 8'h07, 8'h80));
      wait_t0(37);
      datain = 32'h0; dp_in = 8'h00; digit_en = 8'h05;
      wait_t0(41); check_lit("en_d0", actual(0), pk(1'b0, 8'h0E, 8'h3F));
      wait_t0(46); check_lit("en_d1_off", actual(0), pk(1'b0, 8'h0F, 8'h00));
      wait_t0(51); check_lit("en_d2_zero", actual(0), pk(1'b0, 8'h0B, 8'h00));
      wait_t0(59); check_lit("en_d3_fd", actual(0), pk(1'b1, 8'h0F, 8'h00));

      wait_t0(71);
      @(posedge clkin);
      #2 reset = 1'b0;
      #1;
      check_lit("async_rst0", actual(0), pk(1'b0, 8'h0F, 8'h00));
      check_lit("async_rst2", actual(2), pk(1'b0, 8'h07, 8'hFF));
      repeat (2) @(negedge clkin);
      #2 reset = 1'b1;
      wait_t0(1);  check_lit("restart_d0", actual(0), pk(1'b0, 8'h0E, 8'h3F));

      for (int i = 0; i < 3000; i++) begin
         @(negedge clkin);
         #2;
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            repeat (2) @(negedge clkin);
            #2 reset = 1'b1;
         end else if ($urandom_range(0, 29) == 0) begin
            datain   = $urandom >> (4 * $urandom_range(0, 7));
            dp_in    = 8'($urandom);
            digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            lz_blank = 1'($urandom);
         end
      end
      @(negedge clkin);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
